// File: rtl/y_loader.sv
// Program loader: takes a little-endian byte stream, writes the words into
// instruction memory, verifies an XOR checksum and then pulses INT to boot.
module y_loader #(
  parameter logic [31:0] LOAD_BASE = 32'h0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        hold,
  output logic        INT,
  output logic [31:0] entryPoint,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  typedef enum logic [3:0] {
    S_IDLE, S_ENTRY, S_COUNT, S_DATA, S_WRITE, S_CSUM, S_BOOT, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [31:0] entry_q, entry_d;
  logic [15:0] count_q, count_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        xfer;
  logic [15:0] n_full;
  logic [31:0] word_full;

  assign xfer      = in_valid & in_ready;
  assign n_full    = {in_data, count_q[7:0]};
  assign word_full = {in_data, word_q[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      count_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      words_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    word_d  = word_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_ENTRY;
          words_d = '0;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      S_ENTRY: begin
        if (xfer) begin
          entry_d[{idx_q, 3'b000} +: 8] = in_data;
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          csum_d = csum_q ^ in_data;
          if (idx_q == 2'd0) begin
            count_d[7:0] = in_data;
            idx_d        = 2'd1;
          end else begin
            count_d = n_full;
            idx_d   = 2'd0;
            if ({1'b0, n_full} > MAX_W) state_d = S_ERR;
            else if (n_full == 16'd0)   state_d = S_CSUM;
            else                        state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Bytes shift in from the top so the first byte ends up in [7:0].
        if (xfer) begin
          csum_d = csum_q ^ in_data;
          word_d = word_full;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = LOAD_BASE + {14'd0, words_q, 2'b00};
            wdata_d = word_full;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        if (({1'b0, words_q} + 17'd1) < {1'b0, count_q}) state_d = S_DATA;
        else                                            state_d = S_CSUM;
      end
      S_CSUM: begin
        if (xfer) state_d = (in_data == csum_q) ? S_BOOT : S_ERR;
      end
      S_BOOT:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready      = (state_q == S_ENTRY) || (state_q == S_COUNT) ||
                         (state_q == S_DATA)  || (state_q == S_CSUM);
  assign imem_we       = (state_q == S_WRITE);
  assign hold          = in_ready || imem_we;
  assign INT           = (state_q == S_BOOT);
  assign busy          = hold || INT;
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign entryPoint    = entry_q;
  assign words_written = words_q;

endmodule
